// File: rtl/pattern_lut_loader.sv
// pattern_lut_loader
// Streams one full load of 2^MXADRB words into the pattern RAM picked by
// pid_sel. It drives a one-hot write strobe plus address and data into the RAM
// write ports. It also keeps a running checksum and word count so software can
// check the load afterwards.
//
// Handshake: in LOAD a word is taken on every rising edge where wr_ready=1,
// wr_valid=1 and abort=0. wr_ready is high for the whole of LOAD and low in
// every other state. The producer may hold wr_valid low for any number of
// cycles, and each cycle with wr_valid low transfers nothing.
module pattern_lut_loader #(
  parameter int MXADRB = 12,
  parameter int MXDATB = 18,
  parameter int MXPIDB = 4,
  parameter int NPAT   = 11
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic [MXPIDB-1:0] pid_sel,
  input  logic              abort,
  input  logic [MXDATB-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [NPAT-1:0]   ram_we,
  output logic [MXADRB-1:0] ram_adr,
  output logic [MXDATB-1:0] ram_wdata,
  output logic              busy,
  output logic              done,
  output logic              err_pid,
  output logic              err_abort,
  output logic [MXDATB-1:0] checksum,
  output logic [MXADRB:0]   word_cnt,
  output logic [1:0]        dbg_state
);

  // Pattern IDs 0 and 1 have no loadable RAM. The legal range ends at the top strobe.
  localparam logic [MXPIDB-1:0] PID_MIN = MXPIDB'(2);
  localparam logic [MXPIDB-1:0] PID_MAX = MXPIDB'(NPAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t            state_q;
  state_t            state_d;
  logic [MXPIDB-1:0] pid_q;
  logic              pid_legal;
  logic              last_word;
  logic              start_ok;
  logic              start_bad;
  logic              accept;
  logic              abort_load;

  assign pid_legal = (pid_sel >= PID_MIN) && (pid_sel <= PID_MAX);
  // Before the increment, word_cnt never exceeds 2^MXADRB-1 in LOAD, so the low bits all being one marks the final word.
  assign last_word = &word_cnt[MXADRB-1:0];
  assign dbg_state = state_q;

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic, handshake outputs, and the per-cycle event strobes.
  always_comb begin
    state_d    = state_q;
    wr_ready   = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    start_ok   = 1'b0;
    start_bad  = 1'b0;
    accept     = 1'b0;
    abort_load = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (pid_legal) begin
            start_ok = 1'b1;
            state_d  = S_LOAD;
          end else begin
            start_bad = 1'b1;
          end
        end
      end
      S_LOAD: begin
        wr_ready = 1'b1;
        busy     = 1'b1;
        if (abort) begin
          abort_load = 1'b1;
          state_d    = S_IDLE;
        end else if (wr_valid) begin
          accept = 1'b1;
          if (last_word) state_d = S_FIN;
        end
      end
      S_FIN: begin
        // The last write comes out of its register during this cycle.
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath: the latched pid, the error flags, the registered RAM write port, and the counters.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pid_q     <= '0;
      ram_we    <= '0;
      ram_adr   <= '0;
      ram_wdata <= '0;
      checksum  <= '0;
      word_cnt  <= '0;
      err_pid   <= 1'b0;
      err_abort <= 1'b0;
    end else begin
      ram_we <= '0;
      if (start_ok) begin
        pid_q     <= pid_sel;
        checksum  <= '0;
        word_cnt  <= '0;
        err_pid   <= 1'b0;
        err_abort <= 1'b0;
      end
      if (start_bad) begin
        err_pid   <= 1'b1;
        err_abort <= 1'b0;
      end
      if (abort_load) err_abort <= 1'b1;
      if (accept) begin
        ram_we    <= NPAT'(1) << pid_q;
        ram_adr   <= word_cnt[MXADRB-1:0];
        ram_wdata <= wr_data;
        word_cnt  <= word_cnt + (MXADRB+1)'(1);
        checksum  <= checksum + wr_data;
      end
    end
  end

endmodule

// File: tb/tb_pattern_lut_loader.sv
// Directed bench for pattern_lut_loader. Each task drives one scenario and
// checks the outputs 1 time unit after a rising clock edge.
module tb_pattern_lut_loader;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  pid_sel;
  logic        abort;
  logic [17:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic [10:0] ram_we;
  logic [11:0] ram_adr;
  logic [17:0] ram_wdata;
  logic        busy;
  logic        done;
  logic        err_pid;
  logic        err_abort;
  logic [17:0] checksum;
  logic [12:0] word_cnt;
  logic [1:0]  dbg_state;

  int vectors = 0;
  int miscompares = 0;

  pattern_lut_loader dut (
    .clock(clock), .reset_n(reset_n), .start(start), .pid_sel(pid_sel),
    .abort(abort), .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .ram_we(ram_we), .ram_adr(ram_adr), .ram_wdata(ram_wdata), .busy(busy),
    .done(done), .err_pid(err_pid), .err_abort(err_abort), .checksum(checksum),
    .word_cnt(word_cnt), .dbg_state(dbg_state)
  );

  // Clock and global time limit.
  always #5 clock = ~clock;

  initial begin
    #2000000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs;
    start = 1'b0; pid_sel = 4'd0; abort = 1'b0; wr_data = '0; wr_valid = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    idle_inputs();
    tick(); tick();
    vectors++; if ({wr_ready, busy, done, err_pid, err_abort} !== 5'b0) begin miscompares++;
      $display("FAIL reset_flags: got %b expected 00000", {wr_ready, busy, done, err_pid, err_abort}); end
    vectors++; if (ram_we !== 11'h0 || ram_adr !== 12'h0 || ram_wdata !== 18'h0) begin miscompares++;
      $display("FAIL reset_ram: got we=%h adr=%h wd=%h expected all 0", ram_we, ram_adr, ram_wdata); end
    vectors++; if (checksum !== 18'h0 || word_cnt !== 13'h0 || dbg_state !== 2'd0) begin miscompares++;
      $display("FAIL reset_cnt: got sum=%h cnt=%h st=%h expected all 0", checksum, word_cnt, dbg_state); end
    reset_n = 1'b1;
    tick();
    vectors++; if (busy !== 1'b0 || ram_we !== 11'h0) begin miscompares++;
      $display("FAIL reset_release: got busy=%b we=%h expected 0/0", busy, ram_we); end
  endtask

  task automatic test_full_load;
    int bad_we = 0, bad_adr = 0, bad_dat = 0, bad_done = 0, bad_rdy = 0, bad_cnt = 0;
    logic [17:0] exp_sum = '0;
    pid_sel = 4'd5; start = 1'b1;
    tick();
    start = 1'b0; pid_sel = 4'd0;
    vectors++; if (wr_ready !== 1'b1 || busy !== 1'b1) begin miscompares++;
      $display("FAIL full_ready: got rdy=%b busy=%b expected 1/1", wr_ready, busy); end
    wr_valid = 1'b1;
    for (int i = 0; i < 4096; i++) begin
      wr_data = 18'(i);
      exp_sum = exp_sum + 18'(i);
      tick();
      if (ram_we !== 11'h020) bad_we++;
      if (ram_adr !== 12'(i)) bad_adr++;
      if (ram_wdata !== 18'(i)) bad_dat++;
      if (done !== (i == 4095)) bad_done++;
      if (wr_ready !== (i != 4095)) bad_rdy++;
      if (word_cnt !== 13'(i + 1)) bad_cnt++;
    end
    vectors++; if (bad_we != 0) begin miscompares++; $display("FAIL full_we: got %0d bad cycles expected 0", bad_we); end
    vectors++; if (bad_adr != 0) begin miscompares++; $display("FAIL full_adr: got %0d bad cycles expected 0", bad_adr); end
    vectors++; if (bad_dat != 0) begin miscompares++; $display("FAIL full_wdata: got %0d bad cycles expected 0", bad_dat); end
    vectors++; if (bad_done != 0) begin miscompares++; $display("FAIL full_done: got %0d bad cycles expected 0", bad_done); end
    vectors++; if (bad_rdy != 0) begin miscompares++; $display("FAIL full_ready_run: got %0d bad cycles expected 0", bad_rdy); end
    vectors++; if (bad_cnt != 0) begin miscompares++; $display("FAIL full_cnt_run: got %0d bad cycles expected 0", bad_cnt); end
    // wr_valid stays high here, so a 4097th word would show up as a write now.
    tick();
    wr_valid = 1'b0;
    vectors++; if (ram_we !== 11'h0 || busy !== 1'b0 || done !== 1'b0) begin miscompares++;
      $display("FAIL full_after: got we=%h busy=%b done=%b expected 0/0/0", ram_we, busy, done); end
    vectors++; if (word_cnt !== 13'd4096) begin miscompares++;
      $display("FAIL full_word_cnt: got %0d expected 4096", word_cnt); end
    vectors++; if (checksum !== exp_sum) begin miscompares++;
      $display("FAIL full_checksum: got %h expected %h", checksum, exp_sum); end
  endtask

  task automatic test_throttled;
    int sent = 0, writes = 0, bad = 0, bad_gap = 0, done_cyc = 0;
    logic v;
    logic [17:0] exp_sum = '0;
    logic [17:0] w;
    pid_sel = 4'd10; start = 1'b1;
    tick();
    start = 1'b0; pid_sel = 4'd0;
    for (int k = 0; k < 9000 && done_cyc == 0; k++) begin
      v = (k % 2 == 0);
      w = 18'(sent * 5 + 1);
      wr_valid = v; wr_data = w;
      tick();
      if (v) begin
        if (ram_we !== 11'h400 || ram_adr !== 12'(sent) || ram_wdata !== w) bad++;
        exp_sum = exp_sum + w;
        sent++;
      end else if (ram_we !== 11'h0) begin
        bad_gap++;
      end
      if (ram_we === 11'h400) writes++;
      if (done === 1'b1) done_cyc = k + 1;
    end
    wr_valid = 1'b0;
    vectors++; if (writes != 4096) begin miscompares++; $display("FAIL thr_writes: got %0d expected 4096", writes); end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL thr_write_fields: got %0d bad writes expected 0", bad); end
    vectors++; if (bad_gap != 0) begin miscompares++; $display("FAIL thr_gap: got %0d gap writes expected 0", bad_gap); end
    vectors++; if (done_cyc != 8191) begin miscompares++; $display("FAIL thr_done_cycle: got %0d expected 8191", done_cyc); end
    tick();
    vectors++; if (busy !== 1'b0 || word_cnt !== 13'd4096 || checksum !== exp_sum) begin miscompares++;
      $display("FAIL thr_final: got busy=%b cnt=%0d sum=%h expected 0/4096/%h", busy, word_cnt, checksum, exp_sum); end
  endtask

  task automatic test_illegal_pid;
    logic [3:0] bad_pids [2] = '{4'd1, 4'd15};
    for (int n = 0; n < 2; n++) begin
      pid_sel = bad_pids[n]; start = 1'b1;
      tick();
      start = 1'b0;
      vectors++; if (err_pid !== 1'b1 || busy !== 1'b0 || ram_we !== 11'h0) begin miscompares++;
        $display("FAIL bad_pid_%0h: got err=%b busy=%b we=%h expected 1/0/0", bad_pids[n], err_pid, busy, ram_we); end
      wr_valid = 1'b1; wr_data = 18'h12345;
      tick();
      wr_valid = 1'b0;
      vectors++; if (ram_we !== 11'h0 || wr_ready !== 1'b0 || err_pid !== 1'b1) begin miscompares++;
        $display("FAIL bad_pid_idle_%0h: got we=%h rdy=%b err=%b expected 0/0/1", bad_pids[n], ram_we, wr_ready, err_pid); end
    end
    pid_sel = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (err_pid !== 1'b0 || busy !== 1'b1 || word_cnt !== 13'd0) begin miscompares++;
      $display("FAIL pid2_start: got err=%b busy=%b cnt=%0d expected 0/1/0", err_pid, busy, word_cnt); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if (busy !== 1'b0 || err_abort !== 1'b1 || done !== 1'b0) begin miscompares++;
      $display("FAIL pid2_abort: got busy=%b erra=%b done=%b expected 0/1/0", busy, err_abort, done); end
  endtask

  task automatic test_abort;
    int writes = 0, bad = 0;
    logic [17:0] exp_sum = '0;
    logic [17:0] w;
    pid_sel = 4'd3; start = 1'b1;
    tick();
    start = 1'b0;
    vectors++; if (err_abort !== 1'b0 || word_cnt !== 13'd0 || checksum !== 18'd0) begin miscompares++;
      $display("FAIL abort_start: got erra=%b cnt=%0d sum=%h expected 0/0/0", err_abort, word_cnt, checksum); end
    wr_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      // Words near the top of the range make the checksum wrap.
      w = 18'h3FF00 + 18'(i);
      wr_data = w;
      exp_sum = exp_sum + w;
      tick();
      if (ram_we === 11'h008) writes++;
      if (ram_we !== 11'h008 || ram_adr !== 12'(i) || ram_wdata !== w) bad++;
    end
    abort = 1'b1; wr_data = 18'h00777;
    tick();
    abort = 1'b0; wr_valid = 1'b0;
    vectors++; if (writes != 100 || bad != 0) begin miscompares++;
      $display("FAIL abort_writes: got %0d writes %0d bad expected 100/0", writes, bad); end
    vectors++; if (ram_we !== 11'h0 || err_abort !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL abort_cycle: got we=%h erra=%b done=%b busy=%b expected 0/1/0/0", ram_we, err_abort, done, busy); end
    vectors++; if (word_cnt !== 13'd100 || checksum !== exp_sum || ram_adr !== 12'd99) begin miscompares++;
      $display("FAIL abort_hold: got cnt=%0d sum=%h adr=%0d expected 100/%h/99", word_cnt, checksum, ram_adr, exp_sum); end
    abort = 1'b1;
    tick(); tick();
    abort = 1'b0;
    vectors++; if (ram_we !== 11'h0 || done !== 1'b0 || word_cnt !== 13'd100 || err_abort !== 1'b1) begin miscompares++;
      $display("FAIL abort_idle: got we=%h done=%b cnt=%0d erra=%b expected 0/0/100/1", ram_we, done, word_cnt, err_abort); end
  endtask

  task automatic test_start_busy;
    int bad = 0;
    pid_sel = 4'd4; start = 1'b1;
    tick();
    start = 1'b0; pid_sel = 4'd0;
    wr_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wr_data = 18'(i + 7);
      if (i == 5 || i == 6) begin start = 1'b1; pid_sel = 4'd7; end
      else begin start = 1'b0; pid_sel = 4'd0; end
      tick();
      if (ram_we !== 11'h010 || ram_adr !== 12'(i) || word_cnt !== 13'(i + 1)) bad++;
    end
    start = 1'b0; wr_valid = 1'b0;
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL busy_start_writes: got %0d bad cycles expected 0", bad); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    vectors++; if (word_cnt !== 13'd20 || err_pid !== 1'b0 || checksum !== 18'd330) begin miscompares++;
      $display("FAIL busy_start_cnt: got cnt=%0d errp=%b sum=%0d expected 20/0/330", word_cnt, err_pid, checksum); end
  endtask

  task automatic test_reset_mid_load;
    int bad = 0;
    pid_sel = 4'd6; start = 1'b1;
    tick();
    start = 1'b0; pid_sel = 4'd0;
    wr_valid = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      wr_data = 18'(i);
      tick();
      if (ram_we !== 11'h040 || ram_adr !== 12'(i)) bad++;
    end
    vectors++; if (bad != 0) begin miscompares++; $display("FAIL rst_pre_writes: got %0d bad cycles expected 0", bad); end
    wr_data = 18'd2000;
    #2 reset_n = 1'b0;
    #1;
    vectors++; if ({wr_ready, busy, done, err_pid, err_abort} !== 5'b0 || ram_we !== 11'h0) begin miscompares++;
      $display("FAIL rst_async_flags: got flags=%b we=%h expected 0/0", {wr_ready, busy, done, err_pid, err_abort}, ram_we); end
    vectors++; if (ram_adr !== 12'h0 || ram_wdata !== 18'h0 || checksum !== 18'h0 || word_cnt !== 13'h0) begin miscompares++;
      $display("FAIL rst_async_regs: got adr=%h wd=%h sum=%h cnt=%h expected all 0", ram_adr, ram_wdata, checksum, word_cnt); end
    tick(); tick();
    wr_valid = 1'b0;
    reset_n = 1'b1;
    tick();
    vectors++; if (ram_we !== 11'h0 || done !== 1'b0 || err_abort !== 1'b0 || busy !== 1'b0) begin miscompares++;
      $display("FAIL rst_after: got we=%h done=%b erra=%b busy=%b expected 0/0/0/0", ram_we, done, err_abort, busy); end
    pid_sel = 4'd9; start = 1'b1;
    tick();
    start = 1'b0; pid_sel = 4'd0;
    wr_valid = 1'b1; wr_data = 18'h2AAAA;
    tick();
    wr_valid = 1'b0;
    vectors++; if (ram_we !== 11'h200 || ram_adr !== 12'h0 || ram_wdata !== 18'h2AAAA) begin miscompares++;
      $display("FAIL rst_new_write: got we=%h adr=%h wd=%h expected 200/0/2aaaa", ram_we, ram_adr, ram_wdata); end
    vectors++; if (word_cnt !== 13'd1 || checksum !== 18'h2AAAA) begin miscompares++;
      $display("FAIL rst_new_cnt: got cnt=%0d sum=%h expected 1/2aaaa", word_cnt, checksum); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_throttled();
    test_illegal_pid();
    test_abort();
    test_start_busy();
    test_reset_mid_load();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
